// File: rtl/outfifo_sc.sv
// outfifo_sc: single-clock output FIFO with a DAQ-MSB/track-valid write filter and an occupancy threshold flag.
// Optional saturating drop counter, built only when OUTFIFO_DROP_CNT_EN is defined.
module outfifo_sc #(
    parameter int DW          = 50,
    parameter int AW          = 6,
    parameter int DAQ_MSB_BIT = 27,
    parameter int VALID_BIT   = 39,
    parameter int NOSPACE_THR = 2**(AW-1)
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic [DW-1:0] din,
    input  logic          wren,
    input  logic          rden,
    input  logic          trig_info_en,
    output logic [DW-1:0] dout,
    output logic          empty,
    output logic          full,
    output logic [AW:0]   count,
    output logic          no_space_for_daq,
    output logic          overflow,
    output logic [15:0]   drop_cnt
);

    localparam int          DEPTH     = 2**AW;
    localparam logic [AW:0] C_DEPTH   = (AW+1)'(DEPTH);
    localparam logic [AW:0] C_THR     = (AW+1)'(NOSPACE_THR);
    localparam logic [AW:0] C_CNT_ONE = (AW+1)'(1);
    localparam logic [AW-1:0] C_PTR_ONE = AW'(1);

    logic [DW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          r_empty;
    logic          r_full;
    logic          r_nospace;
    logic          r_overflow;
    logic [DW-1:0] r_dout;

    logic          w_accept;
    logic          w_wr;
    logic          w_rd;
    logic          w_ovf_evt;
    logic [AW:0]   w_count_nxt;

    // Words with DAQ-MSB set carry track info; they pass only when valid and enabled.
    assign w_accept  = wren && (!din[DAQ_MSB_BIT] || (din[VALID_BIT] && trig_info_en));
    assign w_rd      = rden && !r_empty;
    assign w_wr      = w_accept && (!r_full || rden);
    assign w_ovf_evt = w_accept && r_full && !rden;

    always_comb begin
        w_count_nxt = r_count;
        if (w_wr && !w_rd) begin
            w_count_nxt = r_count + C_CNT_ONE;
        end else if (w_rd && !w_wr) begin
            w_count_nxt = r_count - C_CNT_ONE;
        end
    end

    // Storage has no reset; after reset the pointers make old contents unreachable.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_empty    <= 1'b1;
            r_full     <= 1'b0;
            r_nospace  <= 1'b0;
            r_overflow <= 1'b0;
            r_dout     <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + C_PTR_ONE;
            end
            if (w_rd) begin
                r_rd_ptr <= r_rd_ptr + C_PTR_ONE;
                r_dout   <= r_mem[r_rd_ptr];
            end
            if (w_ovf_evt) begin
                r_overflow <= 1'b1;
            end
            r_count   <= w_count_nxt;
            r_empty   <= (w_count_nxt == '0);
            r_full    <= (w_count_nxt == C_DEPTH);
            r_nospace <= (w_count_nxt >= C_THR);
        end
    end

`ifdef OUTFIFO_DROP_CNT_EN
    logic [15:0] r_drop_cnt;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_drop_cnt <= '0;
        end else if (w_ovf_evt && (r_drop_cnt != 16'hFFFF)) begin
            r_drop_cnt <= r_drop_cnt + 16'd1;
        end
    end

    assign drop_cnt = r_drop_cnt;
`else
    assign drop_cnt = 16'h0000;
`endif

    assign dout             = r_dout;
    assign empty            = r_empty;
    assign full             = r_full;
    assign count            = r_count;
    assign no_space_for_daq = r_nospace;
    assign overflow         = r_overflow;

endmodule
